// File: rtl/bbox_pkg.sv
// Shared types for the bounding-box crop streamer: coordinates, box corners,
// scan FSM states and the per-pixel sideband flags.
package bbox_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x_min;
        coord_t x_max;
        coord_t y_min;
        coord_t y_max;
    } box_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } bbox_state_t;

    typedef struct packed {
        logic sol;
        logic eol;
        logic eof;
    } pix_flags_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO holding one pixel plus its sol/eol/eof flags.
// The caller never pushes when full and never pops when empty.
module pix_skid_fifo
    import bbox_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [PIX_W-1:0] wr_data,
    input  pix_flags_t       wr_flags,
    input  logic             pop,
    output logic [PIX_W-1:0] rd_data,
    output pix_flags_t       rd_flags,
    output logic [1:0]       count,
    output logic             empty
);

    typedef struct packed {
        logic [PIX_W-1:0] data;
        pix_flags_t       flags;
    } entry_t;

    entry_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: wr_data, flags: wr_flags};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data  = mem[rd_ptr].data;
    assign rd_flags = mem[rd_ptr].flags;
    assign empty    = (count == 2'd0);

endmodule

// File: rtl/bbox_crop_streamer.sv
// Walks a clamped bounding box in raster order through the pixel RAM and streams
// the pixels out with line/frame markers. Optional stats: BBOX_CROP_STATS_EN.
module bbox_crop_streamer
    import bbox_pkg::*;
#(
    parameter int                IMG_W     = 640,
    parameter int                IMG_H     = 480,
    parameter int                PIX_W     = 8,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              box_valid,
    output logic              box_ready,
    input  coord_t            x_min,
    input  coord_t            x_max,
    input  coord_t            y_min,
    input  coord_t            y_max,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rddata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              done,
    output logic              err,
`ifdef BBOX_CROP_STATS_EN
    output logic [PIX_W+21:0] stat_sum,
    output logic [21:0]       stat_nz,
`endif
    output bbox_state_t       state_dbg
);

    // Handshakes: a box transfers on box_valid&box_ready, a pixel on
    // pix_valid&pix_ready; once pix_valid rises, data and flags hold until accepted.

    localparam coord_t            X_LIM      = coord_t'(IMG_W - 1);
    localparam coord_t            Y_LIM      = coord_t'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);

    bbox_state_t       state, state_nxt;
    box_t              box_in;
    logic              box_empty, accept;
    logic [ADDR_W-1:0] row_off;

    coord_t            x_min_q, x_max_q, y_max_q;
    coord_t            cur_x, cur_y;
    logic [ADDR_W-1:0] line_base;
    logic              last_x, last_rd;
    pix_flags_t        cur_flags;

    logic              rd_infl;
    pix_flags_t        rd_flags_q;
    logic              err_q;

    logic [PIX_W-1:0]  head_data;
    pix_flags_t        head_flags;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic              pop;
    logic [2:0]        occupancy;

    always_comb begin
        box_in.x_min = x_min;
        box_in.y_min = y_min;
        box_in.x_max = (x_max > X_LIM) ? X_LIM : x_max;
        box_in.y_max = (y_max > Y_LIM) ? Y_LIM : y_max;
    end

    assign box_empty = (box_in.x_min > box_in.x_max) || (box_in.y_min > box_in.y_max);
    assign box_ready = (state == IDLE) && !err_q;
    assign accept    = box_valid && box_ready;

    // Starting row offset y_min*IMG_W built by shift-and-add.
    always_comb begin
        row_off = '0;
        for (int i = 0; i < COORD_W; i++) begin
            if (y_min[i]) begin
                row_off = row_off + (ROW_STRIDE << i);
            end
        end
    end

    assign last_x        = (cur_x == x_max_q);
    assign last_rd       = last_x && (cur_y == y_max_q);
    assign cur_flags.sol = (cur_x == x_min_q);
    assign cur_flags.eol = last_x;
    assign cur_flags.eof = last_rd;

    // Credit includes the pop happening this cycle so a full-rate stream never bubbles.
    assign pop       = pix_valid && pix_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_infl};
    assign mem_rd    = (state == SCAN) && (occupancy < (pop ? 3'd3 : 3'd2));
    assign mem_addr  = mem_rd ? (line_base + ADDR_W'(cur_x)) : '0;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !box_empty) state_nxt = SCAN;
            end
            SCAN: begin
                if (mem_rd && last_rd) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!rd_infl && fifo_empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            err_q      <= 1'b0;
            rd_infl    <= 1'b0;
            rd_flags_q <= '0;
            x_min_q    <= '0;
            x_max_q    <= '0;
            y_max_q    <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            line_base  <= '0;
        end else begin
            state   <= state_nxt;
            err_q   <= accept && box_empty;
            rd_infl <= mem_rd;
            if (mem_rd) begin
                rd_flags_q <= cur_flags;
            end
            if (accept) begin
                x_min_q   <= box_in.x_min;
                x_max_q   <= box_in.x_max;
                y_max_q   <= box_in.y_max;
                cur_x     <= box_in.x_min;
                cur_y     <= box_in.y_min;
                line_base <= BASE_ADDR + row_off;
            end else if (mem_rd) begin
                if (last_x) begin
                    cur_x     <= x_min_q;
                    cur_y     <= cur_y + 11'd1;
                    line_base <= line_base + ROW_STRIDE;
                end else begin
                    cur_x <= cur_x + 11'd1;
                end
            end
        end
    end

    pix_skid_fifo #(
        .PIX_W (PIX_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_infl),
        .wr_data  (mem_rddata),
        .wr_flags (rd_flags_q),
        .pop      (pop),
        .rd_data  (head_data),
        .rd_flags (head_flags),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign pix_valid = !fifo_empty;
    assign pix_data  = head_data;
    assign pix_sol   = pix_valid && head_flags.sol;
    assign pix_eol   = pix_valid && head_flags.eol;
    assign pix_eof   = pix_valid && head_flags.eof;
    assign err       = err_q;
    assign state_dbg = state;

`ifdef BBOX_CROP_STATS_EN
    localparam int SUM_W = PIX_W + 22;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_sum <= '0;
            stat_nz  <= '0;
        end else if (accept) begin
            stat_sum <= '0;
            stat_nz  <= '0;
        end else if (pop) begin
            stat_sum <= stat_sum + SUM_W'(pix_data);
            if (pix_data != '0) begin
                stat_nz <= stat_nz + 22'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bbox_crop_streamer.sv
// Directed bench for bbox_crop_streamer: an 8-pixel-wide instance for most
// scenarios and a 640x480 instance for the right-edge clamp.
`timescale 1ns/1ps
module tb_bbox_crop_streamer;
  import bbox_pkg::*;

  localparam int PIX_W  = 8;
  localparam int ADDR_W = 32;
  localparam int BW     = PIX_W + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (8x8 image) ----------------
  logic              box_valid = 1'b0;
  logic              box_ready;
  logic [10:0]       x_min = '0, x_max = '0, y_min = '0, y_max = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rddata = '0;
  logic              pix_valid;
  logic              pix_ready = 1'b1;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_sol, pix_eol, pix_eof;
  logic              done, err;
  bbox_state_t       state_dbg;
`ifdef BBOX_CROP_STATS_EN
  logic [PIX_W+21:0] stat_sum;
  logic [21:0]       stat_nz;
`endif

  bbox_crop_streamer #(
    .IMG_W(8), .IMG_H(8), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .BASE_ADDR('0)
  ) u_dut (
    .clk(clk), .rst(rst), .box_valid(box_valid), .box_ready(box_ready),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rddata(mem_rddata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .done(done), .err(err),
`ifdef BBOX_CROP_STATS_EN
    .stat_sum(stat_sum), .stat_nz(stat_nz),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- DUT B (640x480 image) ----------------
  logic              box_valid_b = 1'b0;
  logic              box_ready_b;
  logic [10:0]       x_min_b = '0, x_max_b = '0, y_min_b = '0, y_max_b = '0;
  logic              mem_rd_b;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [PIX_W-1:0]  mem_rddata_b = '0;
  logic              pix_valid_b;
  logic              pix_ready_b = 1'b1;
  logic [PIX_W-1:0]  pix_data_b;
  logic              pix_sol_b, pix_eol_b, pix_eof_b;
  logic              done_b, err_b;
  bbox_state_t       state_dbg_b;
`ifdef BBOX_CROP_STATS_EN
  logic [PIX_W+21:0] stat_sum_b;
  logic [21:0]       stat_nz_b;
`endif

  bbox_crop_streamer #(
    .IMG_W(640), .IMG_H(480), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .BASE_ADDR('0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .box_valid(box_valid_b), .box_ready(box_ready_b),
    .x_min(x_min_b), .x_max(x_max_b), .y_min(y_min_b), .y_max(y_max_b),
    .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rddata(mem_rddata_b),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_data(pix_data_b),
    .pix_sol(pix_sol_b), .pix_eol(pix_eol_b), .pix_eof(pix_eof_b),
    .done(done_b), .err(err_b),
`ifdef BBOX_CROP_STATS_EN
    .stat_sum(stat_sum_b), .stat_nz(stat_nz_b),
`endif
    .state_dbg(state_dbg_b)
  );

  // ---------------- RAM models (1-cycle read latency) ----------------
  logic const_pix = 1'b0;

  function automatic logic [PIX_W-1:0] pix_of(input logic [ADDR_W-1:0] a);
    return const_pix ? 8'h01 : (a[7:0] ^ 8'hA5);
  endfunction

  always @(posedge clk) if (mem_rd)   mem_rddata   <= pix_of(mem_addr);
  always @(posedge clk) if (mem_rd_b) mem_rddata_b <= pix_of(mem_addr_b);

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int beats  = 0;
  logic rand_ready = 1'b0;

  logic [BW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] got_addr[$];

  task automatic push_exp(input int addr, input logic sol, input logic eol, input logic eof);
    exp_q.push_back({pix_of(ADDR_W'(addr)), sol, eol, eof});
  endtask

  // ---------------- scoreboard / protocol monitor on DUT A ----------------
  int            occ_m = 0;
  int            infl_m = 0;
  int            mon_pop;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  logic [BW-1:0] mon_beat;
  logic [BW-1:0] mon_exp;

  always @(negedge clk) begin
    #4;
    if (rst) begin
      occ_m      = 0;
      infl_m     = 0;
      prev_stall = 1'b0;
    end else begin
      mon_beat = {pix_data, pix_sol, pix_eol, pix_eof};
      mon_pop  = (pix_valid && pix_ready) ? 1 : 0;
      checks++;
      if (pix_valid !== (occ_m != 0)) begin
        errors++;
        $display("FAIL pix_valid_vs_fifo @%0t: got %b want %b", $time, pix_valid, occ_m != 0);
      end
      if (mem_rd) begin
        got_addr.push_back(mem_addr);
        checks++;
        if (occ_m + infl_m - mon_pop >= 2) begin
          errors++;
          $display("FAIL read_credit @%0t: got occ+inflight-pop=%0d want <2", $time, occ_m + infl_m - mon_pop);
        end
      end
      if (prev_stall) begin
        checks++;
        if (pix_valid !== 1'b1 || mon_beat !== prev_beat) begin
          errors++;
          $display("FAIL stall_stable @%0t: got v=%b beat=%h want v=1 beat=%h", $time, pix_valid, mon_beat, prev_beat);
        end
      end
      if (mon_pop == 1) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected @%0t: got beat %h want none", $time, mon_beat);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_beat !== mon_exp) begin
            errors++;
            $display("FAIL sb_beat @%0t: got %h want %h", $time, mon_beat, mon_exp);
          end
        end
      end
      occ_m  = occ_m + infl_m - mon_pop;
      infl_m = mem_rd ? 1 : 0;
      if (occ_m > 2) begin
        errors++;
        $display("FAIL fifo_overflow @%0t: got occupancy %0d want <=2", $time, occ_m);
      end
      prev_stall = pix_valid && !pix_ready;
      prev_beat  = mon_beat;
    end
  end

  // ---------------- driver: one box on DUT A, measured per cycle ----------------
  task automatic run_box(input int x0, input int x1, input int y0, input int y1, input int max_cyc,
                         output int first_rd, output int first_pv, output int done_cyc,
                         output int done_n, output logic rdy_after);
    first_rd = -1; first_pv = -1; done_cyc = -1; done_n = 0; rdy_after = 1'b0;
    @(negedge clk);
    box_valid = 1'b1;
    x_min = 11'(x0); x_max = 11'(x1); y_min = 11'(y0); y_max = 11'(y1);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      box_valid = 1'b0;
      if (rand_ready) pix_ready = ($urandom_range(0, 1) == 1);
      #4;
      if (mem_rd && first_rd < 0) first_rd = c;
      if (pix_valid && first_pv < 0) first_pv = c;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        rdy_after = box_ready;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); #4;
    checks++;
    if ({box_ready, mem_rd, pix_valid, done, err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/rd/pv/done/err=%b want 10000", {box_ready, mem_rd, pix_valid, done, err});
    end
    checks++;
    if (mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 0", mem_addr);
    end
    checks++;
    if ({pix_sol, pix_eol, pix_eof} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {pix_sol, pix_eol, pix_eof});
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
    end
    checks++;
    if ({box_ready_b, pix_valid_b, mem_rd_b} !== 3'b100) begin
      errors++;
      $display("FAIL reset_b: got rdy/pv/rd=%b want 100", {box_ready_b, pix_valid_b, mem_rd_b});
    end
`ifdef BBOX_CROP_STATS_EN
    checks++;
    if (stat_sum !== '0 || stat_nz !== '0) begin
      errors++;
      $display("FAIL reset_stats: got sum=%0d nz=%0d want 0 0", stat_sum, stat_nz);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_box();
    int first_rd, first_pv, done_cyc, done_n;
    logic rdy_after;
    int ea[$];
    ea = '{10, 11, 12, 18, 19, 20};
    got_addr.delete();
    beats = 0; pix_ready = 1'b1; rand_ready = 1'b0;
    push_exp(10, 1, 0, 0); push_exp(11, 0, 0, 0); push_exp(12, 0, 1, 0);
    push_exp(18, 1, 0, 0); push_exp(19, 0, 0, 0); push_exp(20, 0, 1, 1);
    run_box(2, 4, 1, 2, 40, first_rd, first_pv, done_cyc, done_n, rdy_after);
    checks++;
    if (first_rd !== 1) begin errors++; $display("FAIL basic_first_rd: got %0d want 1", first_rd); end
    checks++;
    if (first_pv !== 3) begin errors++; $display("FAIL basic_first_valid: got %0d want 3", first_pv); end
    checks++;
    if (done_cyc !== 9) begin errors++; $display("FAIL basic_done_cycle: got %0d want 9", done_cyc); end
    checks++;
    if (done_n !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_n); end
    checks++;
    if (rdy_after !== 1'b1) begin errors++; $display("FAIL basic_ready_after_done: got %b want 1", rdy_after); end
    checks++;
    if (got_addr.size() !== 6) begin
      errors++;
      $display("FAIL basic_read_count: got %0d want 6", got_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_addr[i] !== ADDR_W'(ea[i])) begin
          errors++;
          $display("FAIL basic_addr[%0d]: got %0d want %0d", i, got_addr[i], ea[i]);
        end
      end
    end
    checks++;
    if (beats !== 6 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL basic_beats: got %0d beats, %0d left want 6, 0", beats, exp_q.size());
    end
  endtask

  task automatic test_single_pixel();
    int first_rd, first_pv, done_cyc, done_n;
    logic rdy_after;
    got_addr.delete();
    beats = 0;
    push_exp(45, 1, 1, 1);
    run_box(5, 5, 5, 5, 20, first_rd, first_pv, done_cyc, done_n, rdy_after);
    checks++;
    if (got_addr.size() !== 1 || got_addr[0] !== 32'd45) begin
      errors++;
      $display("FAIL single_addr: got n=%0d addr=%0d want n=1 addr=45", got_addr.size(), got_addr[0]);
    end
    checks++;
    if (done_cyc !== 4) begin errors++; $display("FAIL single_done_cycle: got %0d want 4", done_cyc); end
    checks++;
    if (beats !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL single_beats: got %0d beats, %0d left want 1, 0", beats, exp_q.size());
    end
  endtask

  task automatic test_empty_box();
    int vec[3][4];
    int rd_n;
    vec = '{'{7, 3, 0, 0}, '{9, 20, 0, 0}, '{0, 1, 5, 2}};
    for (int v = 0; v < 3; v++) begin
      rd_n = 0;
      @(negedge clk);
      box_valid = 1'b1;
      x_min = 11'(vec[v][0]); x_max = 11'(vec[v][1]); y_min = 11'(vec[v][2]); y_max = 11'(vec[v][3]);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        box_valid = 1'b0;
        #4;
        if (mem_rd) rd_n++;
        if (c == 1) begin
          checks++;
          if ({err, box_ready} !== 2'b10) begin
            errors++;
            $display("FAIL empty%0d_cycle1: got err/rdy=%b want 10", v, {err, box_ready});
          end
        end
        if (c == 2) begin
          checks++;
          if ({err, box_ready} !== 2'b01) begin
            errors++;
            $display("FAIL empty%0d_cycle2: got err/rdy=%b want 01", v, {err, box_ready});
          end
        end
      end
      checks++;
      if (rd_n !== 0) begin errors++; $display("FAIL empty%0d_reads: got %0d want 0", v, rd_n); end
    end
  endtask

  task automatic test_clamp_wide();
    logic [ADDR_W-1:0] ra[$];
    logic [BW-1:0]     bt[$];
    int done_c;
    done_c = -1;
    @(negedge clk);
    box_valid_b = 1'b1;
    x_min_b = 11'd630; x_max_b = 11'd2000; y_min_b = 11'd0; y_max_b = 11'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      box_valid_b = 1'b0;
      #4;
      if (mem_rd_b) ra.push_back(mem_addr_b);
      if (pix_valid_b && pix_ready_b) bt.push_back({pix_data_b, pix_sol_b, pix_eol_b, pix_eof_b});
      if (done_b) begin
        done_c = c;
        break;
      end
    end
    checks++;
    if (done_c !== 13) begin errors++; $display("FAIL clamp_done_cycle: got %0d want 13", done_c); end
    checks++;
    if (ra.size() !== 10 || bt.size() !== 10) begin
      errors++;
      $display("FAIL clamp_count: got %0d reads %0d beats want 10 10", ra.size(), bt.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (ra[i] !== ADDR_W'(630 + i)) begin
          errors++;
          $display("FAIL clamp_addr[%0d]: got %0d want %0d", i, ra[i], 630 + i);
        end
        checks++;
        if (bt[i] !== {pix_of(ADDR_W'(630 + i)), (i == 0), (i == 9), (i == 9)}) begin
          errors++;
          $display("FAIL clamp_beat[%0d]: got %h want %h", i, bt[i], {pix_of(ADDR_W'(630 + i)), (i == 0), (i == 9), (i == 9)});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int first_rd, first_pv, done_cyc, done_n;
    logic rdy_after;
    beats = 0;
    for (int y = 3; y <= 6; y++)
      for (int x = 1; x <= 4; x++)
        push_exp(y * 8 + x, (x == 1), (x == 4), (x == 4 && y == 6));
    rand_ready = 1'b1;
    run_box(1, 4, 3, 6, 400, first_rd, first_pv, done_cyc, done_n, rdy_after);
    rand_ready = 1'b0;
    pix_ready  = 1'b1;
    checks++;
    if (done_n !== 1) begin errors++; $display("FAIL bp_done: got %0d pulses want 1", done_n); end
    checks++;
    if (beats !== 16 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_beats: got %0d beats, %0d left want 16, 0", beats, exp_q.size());
    end
    checks++;
    if (rdy_after !== 1'b1) begin errors++; $display("FAIL bp_ready_after_done: got %b want 1", rdy_after); end
  endtask

  task automatic test_reset_mid_scan();
    int first_rd, first_pv, done_cyc, done_n;
    logic rdy_after;
    int seen_done;
    int ea[$];
    ea = '{0, 1, 8, 9};
    seen_done = 0;
    @(negedge clk);
    box_valid = 1'b1;
    x_min = 11'd0; x_max = 11'd3; y_min = 11'd0; y_max = 11'd3;
    @(negedge clk);
    box_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #4;
    checks++;
    if ({box_ready, mem_rd, pix_valid, done, err} !== 5'b10000 || mem_addr !== '0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL midrst_outputs: got rdy/rd/pv/done/err=%b addr=%0d st=%0d want 10000 0 %0d",
               {box_ready, mem_rd, pix_valid, done, err}, mem_addr, state_dbg, IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #4;
      if (done || pix_valid || mem_rd) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", seen_done); end
    got_addr.delete();
    beats = 0;
    push_exp(0, 1, 0, 0); push_exp(1, 0, 1, 0); push_exp(8, 1, 0, 0); push_exp(9, 0, 1, 1);
    run_box(0, 1, 0, 1, 30, first_rd, first_pv, done_cyc, done_n, rdy_after);
    checks++;
    if (first_rd !== 1 || done_cyc !== 7) begin
      errors++;
      $display("FAIL midrst_newbox_timing: got rd=%0d done=%0d want 1 7", first_rd, done_cyc);
    end
    checks++;
    if (got_addr.size() !== 4) begin
      errors++;
      $display("FAIL midrst_read_count: got %0d want 4", got_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_addr[i] !== ADDR_W'(ea[i])) begin
          errors++;
          $display("FAIL midrst_addr[%0d]: got %0d want %0d", i, got_addr[i], ea[i]);
        end
      end
    end
    checks++;
    if (beats !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL midrst_beats: got %0d beats, %0d left want 4, 0", beats, exp_q.size());
    end
  endtask

`ifdef BBOX_CROP_STATS_EN
  task automatic test_stats();
    int first_rd, first_pv, done_cyc, done_n;
    logic rdy_after;
    const_pix = 1'b1;
    for (int y = 0; y <= 2; y++)
      for (int x = 0; x <= 2; x++)
        push_exp(y * 8 + x, (x == 0), (x == 2), (x == 2 && y == 2));
    run_box(0, 2, 0, 2, 40, first_rd, first_pv, done_cyc, done_n, rdy_after);
    checks++;
    if (stat_sum !== 30'd9 || stat_nz !== 22'd9) begin
      errors++;
      $display("FAIL stats_3x3: got sum=%0d nz=%0d want 9 9", stat_sum, stat_nz);
    end
    const_pix = 1'b0;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    #1;
    test_reset();
    test_basic_box();
    test_single_pixel();
    test_empty_box();
    test_clamp_wide();
    test_backpressure();
    test_reset_mid_scan();
`ifdef BBOX_CROP_STATS_EN
    test_stats();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
